// File: rtl/fifo_byte_packer.sv
// Packs IN_WIDTH-bit FIFO entries little-endian into BYTES_PER_WORD-lane words on a valid/ready port.
// Optional idle-timeout auto-flush is enabled by defining PACKER_TIMEOUT_FLUSH_EN.
module fifo_byte_packer #(
    parameter int IN_WIDTH       = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int TIMEOUT        = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [IN_WIDTH-1:0]                 inData,
    input  logic                                inAvail,
    output logic                                inTake,
    input  logic                                flush,
    output logic [IN_WIDTH*BYTES_PER_WORD-1:0]  outData,
    output logic [$clog2(BYTES_PER_WORD):0]     outCount,
    output logic                                outValid,
    input  logic                                outReady,
    output logic                                busy
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);
    localparam int CNT_W = $clog2(BYTES_PER_WORD) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             do_flush;
    logic             timeout_flush;

    assign inTake   = inAvail && (state == FILL) && !rst;
    assign accept   = inAvail && inTake;
    assign do_flush = flush || timeout_flush;
    assign busy     = (idx != '0) || outValid;

`ifdef PACKER_TIMEOUT_FLUSH_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_cnt;

    // Firing on the TIMEOUT-th idle edge itself makes the word appear exactly TIMEOUT cycles after the last accept.
    assign timeout_flush = (state == FILL) && (idx != '0) && !accept && !flush
                           && (idle_cnt == IDLE_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || state != FILL || accept || flush || idx == '0 || timeout_flush)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + IDLE_W'(1);
    end
`else
    assign timeout_flush = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            idx      <= '0;
            outValid <= 1'b0;
            outData  <= '0;
            outCount <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (accept)
                        outData[idx*IN_WIDTH +: IN_WIDTH] <= inData;
                    if (accept && idx == LAST_IDX) begin
                        state    <= HOLD;
                        outValid <= 1'b1;
                        outCount <= CNT_W'(BYTES_PER_WORD);
                        idx      <= '0;
                    end else if (do_flush && (accept || idx != '0)) begin
                        // A byte accepted on the flush edge belongs to the flushed word.
                        state    <= HOLD;
                        outValid <= 1'b1;
                        outCount <= accept ? CNT_W'(idx) + CNT_W'(1) : CNT_W'(idx);
                        idx      <= '0;
                    end else if (accept) begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                HOLD: begin
                    if (outReady) begin
                        state    <= FILL;
                        outValid <= 1'b0;
                        outData  <= '0;
                        outCount <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Directed self-checking bench for fifo_byte_packer (default parameters: 8-bit entries, 4 lanes, TIMEOUT=16).
// Timeout expectations follow PACKER_TIMEOUT_FLUSH_EN when defined.
module tb_fifo_byte_packer;

    logic        clk;
    logic        rst;
    logic [7:0]  inData;
    logic        inAvail;
    logic        inTake;
    logic        flush;
    logic [31:0] outData;
    logic [2:0]  outCount;
    logic        outValid;
    logic        outReady;
    logic        busy;

    int checks;
    int failures;

    fifo_byte_packer dut (
        .clk      (clk),
        .rst      (rst),
        .inData   (inData),
        .inAvail  (inAvail),
        .inTake   (inTake),
        .flush    (flush),
        .outData  (outData),
        .outCount (outCount),
        .outValid (outValid),
        .outReady (outReady),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired got=running exp=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        inData  = b;
        inAvail = 1'b1;
        tick();
        inAvail = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; inAvail = 1'b1; flush = 1'b0; outReady = 1'b1; inData = 8'hFF;
        tick(); tick();
        checks++; if (inTake !== 1'b0) begin failures++; $display("[TB] FAIL reset_inTake got=%b exp=0", inTake); end
        checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_outValid got=%b exp=0", outValid); end
        checks++; if (outData !== 32'h0) begin failures++; $display("[TB] FAIL reset_outData got=%h exp=00000000", outData); end
        checks++; if (outCount !== 3'd0) begin failures++; $display("[TB] FAIL reset_outCount got=%0d exp=0", outCount); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0; inAvail = 1'b0;
        tick();
    endtask

    task automatic test_full_word();
        logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            inData = bytes[i]; inAvail = 1'b1;
            #1;
            checks++; if (inTake !== 1'b1) begin failures++; $display("[TB] FAIL full_inTake_fill%0d got=%b exp=1", i, inTake); end
            tick();
            if (i == 2) begin
                checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL full_early_valid got=%b exp=0", outValid); end
            end
        end
        #1;
        checks++; if (outValid !== 1'b1) begin failures++; $display("[TB] FAIL full_outValid got=%b exp=1", outValid); end
        checks++; if (outData !== 32'h44332211) begin failures++; $display("[TB] FAIL full_outData got=%h exp=44332211", outData); end
        checks++; if (outCount !== 3'd4) begin failures++; $display("[TB] FAIL full_outCount got=%0d exp=4", outCount); end
        checks++; if (inTake !== 1'b0) begin failures++; $display("[TB] FAIL full_inTake_hold got=%b exp=0", inTake); end
        inAvail = 1'b0;
        tick();
        checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL full_after_ready_valid got=%b exp=0", outValid); end
        checks++; if (outData !== 32'h0) begin failures++; $display("[TB] FAIL full_after_ready_data got=%h exp=00000000", outData); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL full_after_ready_busy got=%b exp=0", busy); end
    endtask

    task automatic test_flush_partial();
        push(8'hAA); push(8'hBB);
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (outValid !== 1'b1) begin failures++; $display("[TB] FAIL flush_outValid got=%b exp=1", outValid); end
        checks++; if (outData !== 32'h0000BBAA) begin failures++; $display("[TB] FAIL flush_outData got=%h exp=0000BBAA", outData); end
        checks++; if (outCount !== 3'd2) begin failures++; $display("[TB] FAIL flush_outCount got=%0d exp=2", outCount); end
        tick();
        push(8'h77);
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (outData !== 32'h00000077) begin failures++; $display("[TB] FAIL flush_next_lane0 got=%h exp=00000077", outData); end
        checks++; if (outCount !== 3'd1) begin failures++; $display("[TB] FAIL flush_next_count got=%0d exp=1", outCount); end
        tick();
    endtask

    task automatic test_backpressure();
        outReady = 1'b0;
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        inData = 8'h99; inAvail = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (inTake !== 1'b0) begin failures++; $display("[TB] FAIL bp_inTake%0d got=%b exp=0", i, inTake); end
            checks++; if (outData !== 32'h04030201) begin failures++; $display("[TB] FAIL bp_outData%0d got=%h exp=04030201", i, outData); end
            checks++; if (outValid !== 1'b1) begin failures++; $display("[TB] FAIL bp_outValid%0d got=%b exp=1", i, outValid); end
            tick();
        end
        outReady = 1'b1;
        tick();
        inAvail = 1'b0;
        checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL bp_accept_valid got=%b exp=0", outValid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL bp_no_pop_busy got=%b exp=0", busy); end
    endtask

    task automatic test_flush_ignored();
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL ign_idle_valid got=%b exp=0", outValid); end
        checks++; if (outCount !== 3'd0) begin failures++; $display("[TB] FAIL ign_idle_count got=%0d exp=0", outCount); end
        outReady = 1'b0;
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (outCount !== 3'd4) begin failures++; $display("[TB] FAIL ign_hold_count got=%0d exp=4", outCount); end
        outReady = 1'b1;
        tick(); tick();
        checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL ign_not_queued got=%b exp=0", outValid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL ign_busy got=%b exp=0", busy); end
        push(8'h10); push(8'h20);
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (outData !== 32'h0) begin failures++; $display("[TB] FAIL rst_mid_data got=%h exp=00000000", outData); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_busy got=%b exp=0", busy); end
        checks++; if (outValid !== 1'b0 || outCount !== 3'd0) begin failures++; $display("[TB] FAIL rst_mid_out got=%b/%0d exp=0/0", outValid, outCount); end
        push(8'h30);
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (outData !== 32'h00000030 || outCount !== 3'd1) begin failures++; $display("[TB] FAIL rst_mid_restart got=%h/%0d exp=00000030/1", outData, outCount); end
        tick();
    endtask

    task automatic test_flush_coincident();
        push(8'h01); push(8'h02);
        inData = 8'hCC; inAvail = 1'b1; flush = 1'b1;
        tick();
        inAvail = 1'b0; flush = 1'b0;
        checks++; if (outCount !== 3'd3) begin failures++; $display("[TB] FAIL coin_count got=%0d exp=3", outCount); end
        checks++; if (outData !== 32'h00CC0201) begin failures++; $display("[TB] FAIL coin_data got=%h exp=00CC0201", outData); end
        tick();
        push(8'h05); push(8'h06); push(8'h07);
        inData = 8'h08; inAvail = 1'b1; flush = 1'b1;
        tick();
        inAvail = 1'b0; flush = 1'b0;
        checks++; if (outCount !== 3'd4 || outData !== 32'h08070605) begin failures++; $display("[TB] FAIL coin_full got=%h/%0d exp=08070605/4", outData, outCount); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL coin_full_after got=%b exp=0", busy); end
    endtask

    task automatic test_timeout();
        push(8'h5A);
`ifdef PACKER_TIMEOUT_FLUSH_EN
        repeat (15) tick();
        checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL to_early got=%b exp=0", outValid); end
        tick();
        checks++; if (outValid !== 1'b1) begin failures++; $display("[TB] FAIL to_valid got=%b exp=1", outValid); end
        checks++; if (outCount !== 3'd1 || outData !== 32'h0000005A) begin failures++; $display("[TB] FAIL to_word got=%h/%0d exp=0000005A/1", outData, outCount); end
        tick();
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL no_timeout_valid%0d got=%b exp=0", i, outValid); end
        end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL no_timeout_busy got=%b exp=1", busy); end
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (outCount !== 3'd1 || outData !== 32'h0000005A) begin failures++; $display("[TB] FAIL no_timeout_flush got=%h/%0d exp=0000005A/1", outData, outCount); end
        tick();
`endif
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; inData = '0; inAvail = 1'b0; flush = 1'b0; outReady = 1'b1;
        test_reset();
        test_full_word();
        test_flush_partial();
        test_backpressure();
        test_flush_ignored();
        test_flush_coincident();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
